// File: rtl/mdu_ctrl.sv
// Issue/stall controller for a multicycle multiply/divide unit.
// It tracks one in-flight MDU operation and holds younger MDU instructions in EX until that operation finishes.
module mdu_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [3:0]       op,
  input  logic [31:0]      divisor,
  input  logic             flush,
  output logic             stall,
  output logic             start,
  output logic [3:0]       mdu_op,
  output logic             hi_we,
  output logic             lo_we,
  output logic             rd_en,
  output logic             busy,
  output logic             div0,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          is_mul, is_div, is_rd, mdu_cls, go;

  assign is_mul  = (op == 4'd1) || (op == 4'd2);
  assign is_div  = (op == 4'd3) || (op == 4'd4);
  assign is_rd   = (op == 4'd5) || (op == 4'd6);
  assign mdu_cls = (op >= 4'd1) && (op <= 4'd8);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    // Reset gates every strobe, so outputs stay quiet while reset is held.
    stall    = !reset && op_valid && !flush && mdu_cls && busy;
    go       = !reset && op_valid && !flush && !stall;
    start    = go && (is_mul || is_div) && !busy;
    hi_we    = go && (op == 4'd7) && !busy;
    lo_we    = go && (op == 4'd8) && !busy;
    rd_en    = go && is_rd && !busy;
    mdu_op   = (start || hi_we || lo_we || rd_en) ? op : 4'd0;
    case (state)
      IDLE: if (start) begin
        state_nx = is_mul ? MUL : DIV;
        cnt_nx   = is_mul ? CW'(MUL_LAT) : CW'(DIV_LAT);
      end
      MUL, DIV: begin
        cnt_nx = cnt - 1'b1;
        // A waiting instruction issues the cycle after this one, never in the same cycle.
        if (cnt <= CW'(1)) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      div0      <= 1'b0;
      stall_cnt <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      div0  <= start && is_div && (divisor == 32'd0);
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl.
// The reference model tracks the cycle at which the MDU goes free and a running total of stall cycles.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset, op_valid, flush;
  logic [3:0]  op;
  logic [31:0] divisor;

  logic        stall, start, hi_we, lo_we, rd_en, busy, div0;
  logic [3:0]  mdu_op;
  logic [15:0] stall_cnt;

  logic        stall4, start4, hi_we4, lo_we4, rd_en4, busy4, div04;
  logic [3:0]  mdu_op4;
  logic [3:0]  stall_cnt4;

  int checks = 0;
  int errors = 0;

  // Reference state
  longint cyc = 0;
  longint busy_end = 0;
  int     stalls = 0;
  logic   div0_m = 1'b0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .divisor(divisor),
    .flush(flush), .stall(stall), .start(start), .mdu_op(mdu_op), .hi_we(hi_we),
    .lo_we(lo_we), .rd_en(rd_en), .busy(busy), .div0(div0), .stall_cnt(stall_cnt)
  );

  mdu_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op), .divisor(divisor),
    .flush(flush), .stall(stall4), .start(start4), .mdu_op(mdu_op4), .hi_we(hi_we4),
    .lo_we(lo_we4), .rd_en(rd_en4), .busy(busy4), .div0(div04), .stall_cnt(stall_cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Compare at the falling edge, then advance the model on the rising edge.
  task automatic cycle();
    logic m_busy, m_stall, m_go, m_start, m_hi, m_lo, m_rd, mdu_class, lat_mul;
    logic [3:0] m_op;
    @(negedge clk);
    m_busy    = !reset && (cyc < busy_end);
    mdu_class = (op >= 1) && (op <= 8);
    m_stall   = !reset && op_valid && !flush && mdu_class && m_busy;
    m_go      = !reset && op_valid && !flush && !m_stall;
    m_start   = m_go && (op >= 1) && (op <= 4);
    m_hi      = m_go && (op == 7);
    m_lo      = m_go && (op == 8);
    m_rd      = m_go && (op == 5 || op == 6);
    m_op      = (m_start || m_hi || m_lo || m_rd) ? op : 4'd0;
    lat_mul   = (op == 1 || op == 2);
    chk("stall",  32'(stall),  32'(m_stall));
    chk("start",  32'(start),  32'(m_start));
    chk("hi_we",  32'(hi_we),  32'(m_hi));
    chk("lo_we",  32'(lo_we),  32'(m_lo));
    chk("rd_en",  32'(rd_en),  32'(m_rd));
    chk("mdu_op", 32'(mdu_op), 32'(m_op));
    chk("busy",   32'(busy),   32'(cyc < busy_end));
    chk("div0",   32'(div0),   32'(div0_m));
    chk("stall_cnt",   32'(stall_cnt),  32'((stalls > 65535) ? 65535 : stalls));
    chk("stall_cnt4",  32'(stall_cnt4), 32'((stalls > 15) ? 15 : stalls));
    chk("stall4", 32'(stall4), 32'(m_stall));
    @(posedge clk);
    if (reset) begin
      busy_end = 0;
      stalls   = 0;
      div0_m   = 1'b0;
    end else begin
      if (m_stall) stalls++;
      div0_m = m_start && (op == 3 || op == 4) && (divisor == 0);
      if (m_start) busy_end = cyc + 1 + (lat_mul ? 5 : 10);
    end
    cyc++;
    #1;
  endtask

  task automatic drive(input logic r, input logic v, input logic [3:0] o,
                       input logic [31:0] d, input logic f, input int n);
    reset = r; op_valid = v; op = o; divisor = d; flush = f;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    reset = 1'b1; op_valid = 1'b0; op = 4'd0; divisor = 32'd7; flush = 1'b0;
    #1;
    drive(1, 1, 4'd1, 32'd5, 0, 3);          // strobes suppressed during reset
    drive(0, 0, 4'd0, 32'd5, 0, 2);
    // MULT issue then idle until the multiplier drains
    drive(0, 1, 4'd1, 32'd5, 0, 1);
    drive(0, 0, 4'd0, 32'd5, 0, 7);
    // DIV followed by MFLO waiting for the result
    drive(0, 1, 4'd3, 32'd9, 0, 1);
    drive(0, 1, 4'd6, 32'd9, 0, 11);
    chk("stall_cnt_div_wait", 32'(stall_cnt), 32'd10);
    drive(0, 0, 4'd0, 32'd9, 0, 2);
    // DIVU by zero
    drive(0, 1, 4'd4, 32'd0, 0, 1);
    drive(0, 0, 4'd0, 32'd0, 0, 11);
    // MULT in flight, flushed MTHI
    drive(0, 1, 4'd2, 32'd1, 0, 1);
    drive(0, 1, 4'd7, 32'd1, 1, 6);
    drive(0, 0, 4'd0, 32'd1, 0, 1);
    // DIV abandoned by reset, MULT issues right after
    drive(0, 1, 4'd3, 32'd3, 0, 1);
    drive(0, 0, 4'd0, 32'd3, 0, 3);
    drive(1, 0, 4'd0, 32'd3, 0, 1);
    drive(0, 1, 4'd1, 32'd3, 0, 1);
    drive(0, 0, 4'd0, 32'd3, 0, 6);
    // Back-to-back DIVs hold the stall long enough to saturate the 4-bit counter
    drive(0, 1, 4'd3, 32'd2, 0, 24);
    drive(0, 1, 4'd5, 32'd2, 0, 12);
    chk("stall_cnt4_sat", 32'(stall_cnt4), 32'd15);
    drive(0, 0, 4'd0, 32'd2, 0, 1);
    // Unused opcodes
    for (int o = 9; o < 16; o++) drive(0, 1, 4'(o), 32'd0, 0, 1);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)),
            ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom),
            ($urandom_range(0, 7) == 0), 1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
